usram_triport_array: RTL and testbench

//  Parametrised single-clock successor to the uSRAM tri-port macro: 1 write port (C), 2 read ports (A, B).

---
 rtl/usram_triport_array.sv | 171 +++++++++++++++++
 tb/tb_usram_triport_array.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usram_triport_array.sv
// Single-clock 1-write / 2-read RAM wrapper around the uSRAM tri-port primitive.
// Hardware clear after reset or on request, optional read pipeline stage, same-address collision flags.
module usram_triport_array #(
  parameter int                    DATA_WIDTH     = 18,
  parameter int                    ADDR_WIDTH     = 6,
  parameter int                    READ_PIPE      = 0,
  parameter int                    COLLISION_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_din,
  output logic                  wr_drop,
  input  logic                  a_re,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  output logic                  a_coll,
  input  logic                  b_re,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  b_coll
);

  localparam int                  DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [ADDR_WIDTH:0]   w_ptr_next;
  logic                  r_busy;
  logic                  r_wr_drop;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_din;

  assign w_ptr_next = r_ptr + PTR_ONE;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= c_we & r_busy;
      case (r_state)
        ST_CLEAR: begin
          r_ptr <= w_ptr_next;
          // Carry into the pointer MSB means the last word is being written now.
          if (w_ptr_next[ADDR_WIDTH]) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (init_req) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear engine and port C.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_mem_we   = 1'b0;
    w_mem_addr = c_addr;
    w_mem_din  = c_din;
    if (!rst) begin
      if (r_busy) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_ptr[ADDR_WIDTH-1:0];
        w_mem_din  = INIT_VALUE;
      end else if (c_we) begin
        w_mem_we = 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch; the clear engine initialises it so it still maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  logic [1:0]            w_re;
  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_dout  [2];
  logic [1:0]            w_valid;
  logic [1:0]            w_coll;

  assign w_re       = {b_re, a_re};
  assign w_raddr[0] = a_addr;
  assign w_raddr[1] = b_addr;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  w_acc;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  r_v1;
    logic                  r_c1;
    logic [DATA_WIDTH-1:0] r_d1;

    assign w_acc   = w_re[p] & ~r_busy;
    assign w_hit   = w_acc & c_we & (w_raddr[p] == c_addr);
    // The array read returns the pre-write word; write-first mode bypasses it with c_din.
    assign w_rdata = (COLLISION_MODE == 1 && w_hit) ? c_din : r_mem[w_raddr[p]];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v1 <= 1'b0;
        r_c1 <= 1'b0;
        r_d1 <= '0;
      end else begin
        r_v1 <= w_acc;
        r_c1 <= w_hit;
        if (w_acc) r_d1 <= w_rdata;
      end
    end

    if (READ_PIPE == 1) begin : g_pipe
      logic                  r_v2;
      logic                  r_c2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_c2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          r_c2 <= r_c1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign w_valid[p] = r_v2;
      assign w_coll[p]  = r_c2;
      assign w_dout[p]  = r_d2;
    end else begin : g_nopipe
      assign w_valid[p] = r_v1;
      assign w_coll[p]  = r_c1;
      assign w_dout[p]  = r_d1;
    end
  end

  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;
  assign a_dout  = w_dout[0];
  assign a_valid = w_valid[0];
  assign a_coll  = w_coll[0];
  assign b_dout  = w_dout[1];
  assign b_valid = w_valid[1];
  assign b_coll  = w_coll[1];

endmodule

// File: tb/tb_usram_triport_array.sv
// Directed + model-checked bench for usram_triport_array: u_d0 (no pipe, read-old, init 0)
// and u_d1 (one pipe stage, write-first, nonzero init) driven by the same stimulus.
module tb_usram_triport_array;

  localparam int            DW    = 18;
  localparam int            AW    = 6;
  localparam int            DEPTH = 64;
  localparam logic [DW-1:0] INIT1 = 18'h0C3C3;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_din;
  logic          a_re, b_re;
  logic [AW-1:0] a_addr, b_addr;

  logic          busy0, wr_drop0, a_valid0, a_coll0, b_valid0, b_coll0;
  logic [DW-1:0] a_dout0, b_dout0;
  logic          busy1, wr_drop1, a_valid1, a_coll1, b_valid1, b_coll1;
  logic [DW-1:0] a_dout1, b_dout1;

  usram_triport_array #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PIPE(0), .COLLISION_MODE(0), .INIT_VALUE('0)
  ) u_d0 (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy0),
    .c_we(c_we), .c_addr(c_addr), .c_din(c_din), .wr_drop(wr_drop0),
    .a_re(a_re), .a_addr(a_addr), .a_dout(a_dout0), .a_valid(a_valid0), .a_coll(a_coll0),
    .b_re(b_re), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0), .b_coll(b_coll0)
  );

  usram_triport_array #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PIPE(1), .COLLISION_MODE(1), .INIT_VALUE(INIT1)
  ) u_d1 (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy1),
    .c_we(c_we), .c_addr(c_addr), .c_din(c_din), .wr_drop(wr_drop1),
    .a_re(a_re), .a_addr(a_addr), .a_dout(a_dout1), .a_valid(a_valid1), .a_coll(a_coll1),
    .b_re(b_re), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1), .b_coll(b_coll1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs a read response as {valid, coll, dout} for a single comparison.
  function automatic logic [63:0] rsp(input logic v, input logic c, input logic [DW-1:0] d);
    return {44'd0, v, c, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    init_req = 1'b0;
    c_we     = 1'b0;
    a_re     = 1'b0;
    b_re     = 1'b0;
  endtask

  // Counts samples with busy high, starting with the current one; bounded at 200 cycles.
  task automatic count_busy(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 200 && (busy0 || busy1); i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      tick();
    end
  endtask

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  initial begin
    int            nb0, nb1;
    logic          re    [2];
    logic [AW-1:0] ra    [2];
    logic          coll  [2];
    logic [DW-1:0] held0 [2];
    logic [DW-1:0] held1 [2];
    logic          pv    [2];
    logic          pc    [2];
    logic [DW-1:0] pd    [2];
    logic [63:0]   exp0  [2];
    logic [63:0]   exp1  [2];

    idle();
    rst = 1'b1; c_addr = '0; c_din = '0; a_addr = '0; b_addr = '0;

    // 1: reset state, clear length, first read
    tick();
    check("rst_busy",    {busy1, busy0}, 2'b11);
    check("rst_wr_drop", {wr_drop1, wr_drop0}, 2'b00);
    check("rst_a_d0",    rsp(a_valid0, a_coll0, a_dout0), rsp(0, 0, '0));
    check("rst_b_d1",    rsp(b_valid1, b_coll1, b_dout1), rsp(0, 0, '0));
    rst = 1'b0;
    count_busy(nb0, nb1);
    check("clr_len_d0", nb0, 64);
    check("clr_len_d1", nb1, 64);
    check("clr_done", {busy1, busy0}, 2'b00);

    a_re = 1'b1; a_addr = 6'h3F;
    tick(); idle();
    check("rd3f_d0",       rsp(a_valid0, a_coll0, a_dout0), rsp(1, 0, '0));
    check("rd3f_d1_early", a_valid1, 1'b0);
    tick();
    check("rd3f_d1",       rsp(a_valid1, a_coll1, a_dout1), rsp(1, 0, INIT1));
    check("rd3f_d0_end",   a_valid0, 1'b0);

    // 2: write then read, latency 1 vs 2, hold between valids
    c_we = 1'b1; c_addr = 6'd5; c_din = 18'h2A5A5;
    tick(); idle();
    a_re = 1'b1; a_addr = 6'd5;
    tick(); idle();
    check("wr5_d0",      rsp(a_valid0, a_coll0, a_dout0), rsp(1, 0, 18'h2A5A5));
    check("wr5_d1_early", a_valid1, 1'b0);
    tick();
    check("wr5_d1",      rsp(a_valid1, a_coll1, a_dout1), rsp(1, 0, 18'h2A5A5));
    check("wr5_d0_hold", rsp(a_valid0, a_coll0, a_dout0), rsp(0, 0, 18'h2A5A5));

    // 3: same-address collision on both read ports
    c_we = 1'b1; c_addr = 6'd9; c_din = 18'h00111;
    tick(); idle();
    c_we = 1'b1; c_addr = 6'd9; c_din = 18'h00222;
    a_re = 1'b1; a_addr = 6'd9; b_re = 1'b1; b_addr = 6'd9;
    tick(); idle();
    check("coll_a_d0", rsp(a_valid0, a_coll0, a_dout0), rsp(1, 1, 18'h00111));
    check("coll_b_d0", rsp(b_valid0, b_coll0, b_dout0), rsp(1, 1, 18'h00111));
    tick();
    check("coll_a_d1", rsp(a_valid1, a_coll1, a_dout1), rsp(1, 1, 18'h00222));
    check("coll_b_d1", rsp(b_valid1, b_coll1, b_dout1), rsp(1, 1, 18'h00222));
    check("coll_a_d0_end", rsp(a_valid0, a_coll0, a_dout0), rsp(0, 0, 18'h00111));
    a_re = 1'b1; a_addr = 6'd9;
    tick(); idle();
    check("after_coll_d0", rsp(a_valid0, a_coll0, a_dout0), rsp(1, 0, 18'h00222));
    tick();
    check("after_coll_d1", rsp(a_valid1, a_coll1, a_dout1), rsp(1, 0, 18'h00222));

    // 5a: init_req clears the whole array
    c_we = 1'b1; c_addr = 6'd2; c_din = 18'h00003;
    tick(); idle();
    init_req = 1'b1;
    tick(); idle();
    check("init_busy", {busy1, busy0}, 2'b11);
    count_busy(nb0, nb1);
    check("init_len_d0", nb0, 64);
    check("init_len_d1", nb1, 64);
    a_re = 1'b1; a_addr = 6'd2; b_re = 1'b1; b_addr = 6'd5;
    tick(); idle();
    check("init_a_d0", rsp(a_valid0, a_coll0, a_dout0), rsp(1, 0, '0));
    check("init_b_d0", rsp(b_valid0, b_coll0, b_dout0), rsp(1, 0, '0));
    tick();
    check("init_a_d1", rsp(a_valid1, a_coll1, a_dout1), rsp(1, 0, INIT1));
    check("init_b_d1", rsp(b_valid1, b_coll1, b_dout1), rsp(1, 0, INIT1));

    // 4 + 5b: traffic during clear is dropped, reset mid-clear restarts it
    init_req = 1'b1;
    tick(); idle();
    c_we = 1'b1; c_addr = 6'd7; c_din = 18'h3FFFF;
    a_re = 1'b1; a_addr = 6'd9; b_re = 1'b1; b_addr = 6'd7;
    tick(); idle();
    check("drop_pulse", {wr_drop1, wr_drop0}, 2'b11);
    check("busy_rd_d0", {b_valid0, a_valid0}, 2'b00);
    tick();
    check("drop_end",   {wr_drop1, wr_drop0}, 2'b00);
    check("busy_rd_d1", {b_valid1, a_valid1}, 2'b00);
    repeat (28) tick();
    check("busy_c30", {busy1, busy0}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_a_d1", rsp(a_valid1, a_coll1, a_dout1), rsp(0, 0, '0));
    count_busy(nb0, nb1);
    check("rst2_len_d0", nb0, 64);
    check("rst2_len_d1", nb1, 64);
    a_re = 1'b1; a_addr = 6'd7; b_re = 1'b1; b_addr = 6'd9;
    tick(); idle();
    check("drop7_d0", rsp(a_valid0, a_coll0, a_dout0), rsp(1, 0, '0));
    check("clr9_d0",  rsp(b_valid0, b_coll0, b_dout0), rsp(1, 0, '0));
    tick();
    check("drop7_d1", rsp(a_valid1, a_coll1, a_dout1), rsp(1, 0, INIT1));
    check("clr9_d1",  rsp(b_valid1, b_coll1, b_dout1), rsp(1, 0, INIT1));

    // 6: random traffic against a behavioural model
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = '0;
      mem1[i] = INIT1;
    end
    for (int p = 0; p < 2; p++) begin
      held0[p] = '0;
      held1[p] = INIT1;
      pv[p]    = 1'b0;
      pc[p]    = 1'b0;
      pd[p]    = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c_we   = ($urandom_range(0, 1) == 1);
      c_din  = DW'($urandom);
      c_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) begin
        re[p] = ($urandom_range(0, 3) != 0);
        ra[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
      end
      a_re = re[0]; a_addr = ra[0];
      b_re = re[1]; b_addr = ra[1];
      for (int p = 0; p < 2; p++) begin
        coll[p] = re[p] && c_we && (ra[p] == c_addr);
        if (re[p]) begin
          held0[p] = mem0[ra[p]];
          exp0[p]  = rsp(1'b1, coll[p], mem0[ra[p]]);
        end else begin
          exp0[p]  = rsp(1'b0, 1'b0, held0[p]);
        end
        if (pv[p]) begin
          held1[p] = pd[p];
          exp1[p]  = rsp(1'b1, pc[p], pd[p]);
        end else begin
          exp1[p]  = rsp(1'b0, 1'b0, held1[p]);
        end
        pv[p] = re[p];
        pc[p] = coll[p];
        pd[p] = coll[p] ? c_din : mem1[ra[p]];
      end
      if (c_we) begin
        mem0[c_addr] = c_din;
        mem1[c_addr] = c_din;
      end
      tick();
      check("rnd_a_d0", rsp(a_valid0, a_coll0, a_dout0), exp0[0]);
      check("rnd_b_d0", rsp(b_valid0, b_coll0, b_dout0), exp0[1]);
      check("rnd_a_d1", rsp(a_valid1, a_coll1, a_dout1), exp1[0]);
      check("rnd_b_d1", rsp(b_valid1, b_coll1, b_dout1), exp1[1]);
      check("rnd_ctl",  {busy1, busy0, wr_drop1, wr_drop0}, 4'b0000);
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
